// File: rtl/addsub_pkg.sv
// addsub_pkg: FSM state encoding and default slice count shared by the add/sub sequencer.
package addsub_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int N_NIBBLES_DEF = 4;
endpackage

// File: rtl/addsub_seq_ctrl_nibble_adder.sv
// nibble_adder: combinational 4-bit adder exposing the carry into bit 3 for overflow detection.
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);
    logic [3:0] lo;

    assign lo        = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    assign c3        = lo[3];
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: W-bit two's-complement add/subtract computed one nibble per cycle
// through a single shared nibble_adder, with valid/ready handshakes on both sides.
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter  int N_NIBBLES = N_NIBBLES_DEF,
    localparam int W         = 4 * N_NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         ovfl,
    output logic         cout,
    output logic         zero,
    output logic         busy
);
    localparam int IW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

    state_t          state, nxt;
    logic [IW-1:0]   idx;
    logic            carry_reg;
    logic            sub_reg;
    logic [W-1:0]    a_reg, b_reg;
    logic [W-1:0]    sum_nx;
    logic [3:0]      na, nb, ns;
    logic            c3, co, last;

    assign last = idx == IW'(N_NIBBLES - 1);
    assign na   = a_reg[4*idx +: 4];
    // Subtraction is A + ~B + 1; the +1 comes from carry_reg seeded with is_sub.
    assign nb   = b_reg[4*idx +: 4] ^ {4{sub_reg}};

    nibble_adder u_nib (
        .a    (na),
        .b    (nb),
        .cin  (carry_reg),
        .s    (ns),
        .c3   (c3),
        .cout (co)
    );

    always_comb begin
        sum_nx            = sum;
        sum_nx[4*idx +: 4] = ns;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = in_valid ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            ovfl      <= 1'b0;
            cout      <= 1'b0;
            zero      <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= is_sub;
            carry_reg <= is_sub;
            idx       <= '0;
        end else if (state == RUN) begin
            sum       <= sum_nx;
            carry_reg <= co;
            idx       <= last ? '0 : idx + 1'b1;
            if (last) begin
                ovfl <= c3 ^ co;
                cout <= co;
                zero <= ~|sum_nx;
            end
        end
    end

    // in_ready is masked by rst_n so every output reads 0 while reset is held.
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
endmodule
